// File: rtl/multicycle_fsm_control_pkg.sv
// Shared control/datapath constants for the multicycle RISC-V core:
// state encodings, opcodes, ALU operation codes and immediate formats.
package multicycle_fsm_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_JALRWB   = 4'd11,
    S_BRANCH   = 4'd12,
    S_AUIPC    = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_LUI    = 7'h37;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:        imm_src = IMM_S;
      OP_BRANCH:       imm_src = IMM_B;
      OP_JAL:          imm_src = IMM_J;
      OP_AUIPC, OP_LUI: imm_src = IMM_U;
      default:         imm_src = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_fsm_control_alu_decoder.sv
// ALU operation decode: R/I-type function fields in the execute states,
// SUB for branch compare, ADD everywhere else (address and PC arithmetic).
module alu_decoder
  import multicycle_fsm_control_pkg::*;
(
  input  state_t     i_state,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [3:0] o_alu_op
);

  always_comb begin
    o_alu_op = ALU_ADD;
    case (i_state)
      S_EXECR: begin
        case (i_funct7)
          7'h00: begin
            case (i_funct3)
              3'b110:  o_alu_op = ALU_OR;
              3'b111:  o_alu_op = ALU_AND;
              default: o_alu_op = ALU_ADD;
            endcase
          end
          7'h20:   o_alu_op = ALU_SUB;
          7'h01:   o_alu_op = ALU_MUL;
          default: o_alu_op = ALU_ADD;
        endcase
      end
      S_EXECI: begin
        case (i_funct3)
          3'b001:  o_alu_op = ALU_SLL;
          3'b010:  o_alu_op = ALU_SLT;
          3'b101:  o_alu_op = ALU_SRL;
          default: o_alu_op = ALU_ADD;
        endcase
      end
      S_BRANCH: o_alu_op = ALU_SUB;
      default:  o_alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_fsm_control.sv
// Multicycle RISC-V main controller: state register plus combinational
// per-state control outputs; memory states stall on MemReady.
module multicycle_fsm_control
  import multicycle_fsm_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  input  logic       zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUOp,
  output logic       IllegalInstr,
  output logic [3:0] State
);

  state_t r_state;
  logic   w_pcw, w_irw, w_mw, w_rw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else begin
      case (r_state)
        S_FETCH:    if (MemReady) r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_RTYPE:          r_state <= S_EXECR;
            OP_ITYPE:          r_state <= S_EXECI;
            OP_JAL:            r_state <= S_JAL;
            OP_JALR:           r_state <= S_JALR;
            OP_BRANCH:         r_state <= S_BRANCH;
            OP_AUIPC:          r_state <= S_AUIPC;
            default:           r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (MemReady) r_state <= S_MEMWB;
        S_MEMWRITE: if (MemReady) r_state <= S_FETCH;
        S_EXECR, S_EXECI, S_JAL, S_AUIPC: r_state <= S_ALUWB;
        S_JALR:     r_state <= S_JALRWB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  alu_decoder u_alu_dec (
    .i_state  (r_state),
    .i_funct3 (Funct3),
    .i_funct7 (Funct7),
    .o_alu_op (ALUOp)
  );

  always_comb begin
    w_pcw        = 1'b0;
    w_irw        = 1'b0;
    w_mw         = 1'b0;
    w_rw         = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    IllegalInstr = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irw     = MemReady;
        w_pcw     = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
          OP_JAL, OP_JALR, OP_BRANCH, OP_AUIPC: IllegalInstr = 1'b0;
          default:                              IllegalInstr = 1'b1;
        endcase
      end
      S_MEMADR, S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_rw      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        w_mw   = 1'b1;
      end
      S_EXECR: ALUSrcA = 2'b10;
      S_ALUWB: w_rw = 1'b1;
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        w_pcw   = 1'b1;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_pcw     = 1'b1;
      end
      S_JALRWB: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_rw      = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        case (Funct3)
          3'b000:  w_pcw = zero;
          3'b001:  w_pcw = ~zero;
          default: w_pcw = 1'b0;
        endcase
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      default: ;
    endcase
  end

  // FETCH follows MemReady combinationally, so strobes are masked during reset
  assign PCWrite  = w_pcw & ~reset;
  assign IRWrite  = w_irw & ~reset;
  assign MemWrite = w_mw  & ~reset;
  assign RegWrite = w_rw  & ~reset;
  assign ImmSrc   = imm_src(opcode);
  assign State    = r_state;

endmodule

// File: tb/tb_multicycle_fsm_control.sv
// Bench: per-instruction expected cycle tables built from the instruction
// semantics, replayed against the controller with directed and random cases.
module tb_multicycle_fsm_control;
  import multicycle_fsm_control_pkg::*;

  logic       clk = 1'b0, reset = 1'b1;
  logic [6:0] opcode = 7'h00, Funct7 = 7'h00;
  logic [2:0] Funct3 = 3'b000;
  logic       zero = 1'b0, MemReady = 1'b1;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, IllegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUOp, State;

  multicycle_fsm_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .Funct3(Funct3), .Funct7(Funct7),
    .zero(zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUOp(ALUOp), .IllegalInstr(IllegalInstr), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, irw, mw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] imm;
    logic [3:0] aop;
    logic       ill;
  } exp_t;

  exp_t q[$];
  bit   mq[$];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic exp_t observed();
    observed = '{State, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp, IllegalInstr};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'h23: imm_of = 3'b001;
      7'h63: imm_of = 3'b010;
      7'h6F: imm_of = 3'b011;
      7'h17, 7'h37: imm_of = 3'b100;
      default: imm_of = 3'b000;
    endcase
  endfunction

  function automatic exp_t base(input state_t s, input logic [6:0] op);
    base = '0;
    base.st = s;
    base.aop = 4'b0010;
    base.imm = imm_of(op);
  endfunction

  function automatic logic [3:0] r_alu(input logic [2:0] f3, input logic [6:0] f7);
    if (f7 == 7'h20) return 4'b0011;
    if (f7 == 7'h01) return 4'b0111;
    if (f7 != 7'h00) return 4'b0010;
    if (f3 == 3'b110) return 4'b0001;
    if (f3 == 3'b111) return 4'b0000;
    return 4'b0010;
  endfunction

  function automatic logic [3:0] i_alu(input logic [2:0] f3);
    case (f3)
      3'b001: return 4'b0100;
      3'b010: return 4'b0110;
      3'b101: return 4'b0101;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic push(input bit mr, input exp_t e);
    q.push_back(e);
    mq.push_back(mr);
  endtask

  // Build one instruction's expected cycles (wf/wm = not-ready cycles before
  // fetch / data access completes), then replay it against the DUT.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input int wf, input int wm);
    exp_t e, wb;
    q.delete(); mq.delete();
    e = base(S_FETCH, op); e.sb = 2'b10; e.rs = 2'b10;
    repeat (wf) push(1'b0, e);
    e.irw = 1'b1; e.pcw = 1'b1; push(1'b1, e);
    e = base(S_DECODE, op); e.sa = 2'b01; e.sb = 2'b01;
    wb = base(S_ALUWB, op); wb.rw = 1'b1;
    case (op)
      7'h03, 7'h23: begin
        push(1'($urandom), e);
        e = base(S_MEMADR, op); e.sa = 2'b10; e.sb = 2'b01; push(1'($urandom), e);
        if (op == 7'h03) begin
          e = base(S_MEMREAD, op); e.adr = 1'b1;
          repeat (wm) push(1'b0, e);
          push(1'b1, e);
          e = base(S_MEMWB, op); e.rs = 2'b01; e.rw = 1'b1; push(1'($urandom), e);
        end else begin
          e = base(S_MEMWRITE, op); e.adr = 1'b1; e.mw = 1'b1;
          repeat (wm) push(1'b0, e);
          push(1'b1, e);
        end
      end
      7'h33: begin
        push(1'($urandom), e);
        e = base(S_EXECR, op); e.sa = 2'b10; e.aop = r_alu(f3, f7); push(1'($urandom), e);
        push(1'($urandom), wb);
      end
      7'h13: begin
        push(1'($urandom), e);
        e = base(S_EXECI, op); e.sa = 2'b10; e.sb = 2'b01; e.aop = i_alu(f3);
        push(1'($urandom), e);
        push(1'($urandom), wb);
      end
      7'h6F: begin
        push(1'($urandom), e);
        e = base(S_JAL, op); e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; push(1'($urandom), e);
        push(1'($urandom), wb);
      end
      7'h67: begin
        push(1'($urandom), e);
        e = base(S_JALR, op); e.sa = 2'b10; e.sb = 2'b01; e.rs = 2'b10; e.pcw = 1'b1;
        push(1'($urandom), e);
        e = base(S_JALRWB, op); e.sa = 2'b01; e.sb = 2'b10; e.rs = 2'b10; e.rw = 1'b1;
        push(1'($urandom), e);
      end
      7'h63: begin
        push(1'($urandom), e);
        e = base(S_BRANCH, op); e.sa = 2'b10; e.aop = 4'b0011;
        e.pcw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? ~z : 1'b0;
        push(1'($urandom), e);
      end
      7'h17: begin
        push(1'($urandom), e);
        e = base(S_AUIPC, op); e.sa = 2'b01; e.sb = 2'b01; push(1'($urandom), e);
        push(1'($urandom), wb);
      end
      default: begin
        e.ill = 1'b1;
        push(1'($urandom), e);
      end
    endcase
    foreach (q[i]) begin
      @(negedge clk);
      opcode = op; Funct3 = f3; Funct7 = f7; zero = z; MemReady = mq[i];
      #1 chk($sformatf("%s c%0d", tag, i), 32'(observed()), 32'(q[i]));
    end
  endtask

  logic [6:0] ops [0:11];
  logic [6:0] rop;

  initial begin
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h67, 7'h63, 7'h17, 7'h7F, 7'h37, 7'h00, 7'h33};
    // reset holds FETCH with strobes masked even though MemReady=1
    #2;
    chk("rst_state", 32'(State), 32'(S_FETCH));
    chk("rst_irw", 32'(IRWrite), 32'd0);
    chk("rst_pcw", 32'(PCWrite), 32'd0);
    @(negedge clk) chk("rst_held", 32'(State), 32'(S_FETCH));
    reset = 1'b0; MemReady = 1'b0;

    run_instr("lw_after_rst", 7'h03, 3'b010, 7'h00, 1'b0, 0, 0);
    run_instr("sw_wait3", 7'h23, 3'b010, 7'h00, 1'b0, 0, 3);
    run_instr("lw_waits", 7'h03, 3'b010, 7'h00, 1'b1, 2, 2);
    run_instr("beq_z1", 7'h63, 3'b000, 7'h00, 1'b1, 0, 0);
    run_instr("bne_z1", 7'h63, 3'b001, 7'h00, 1'b1, 0, 0);
    run_instr("bne_z0", 7'h63, 3'b001, 7'h00, 1'b0, 0, 0);
    run_instr("b_f3_010", 7'h63, 3'b010, 7'h00, 1'b1, 0, 0);
    run_instr("r_sub", 7'h33, 3'b000, 7'h20, 1'b0, 0, 0);
    run_instr("r_mul", 7'h33, 3'b000, 7'h01, 1'b0, 0, 0);
    run_instr("r_or", 7'h33, 3'b110, 7'h00, 1'b0, 0, 0);
    run_instr("i_sll", 7'h13, 3'b001, 7'h00, 1'b0, 0, 0);
    run_instr("jal", 7'h6F, 3'b000, 7'h00, 1'b0, 1, 0);
    run_instr("jalr", 7'h67, 3'b000, 7'h00, 1'b0, 0, 0);
    run_instr("auipc", 7'h17, 3'b000, 7'h00, 1'b0, 0, 0);
    run_instr("illegal_7f", 7'h7F, 3'b000, 7'h00, 1'b0, 0, 0);
    run_instr("after_ill", 7'h13, 3'b010, 7'h00, 1'b0, 0, 0);

    // reset in the middle of a store's MEMWRITE stall
    @(negedge clk) opcode = 7'h23; MemReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk) MemReady = 1'b0;
    #1 chk("mw_pre_state", 32'(State), 32'(S_MEMWRITE));
    chk("mw_pre_strobe", 32'(MemWrite), 32'd1);
    #1 reset = 1'b1; MemReady = 1'b1;
    #1 chk("mw_rst_state", 32'(State), 32'(S_FETCH));
    chk("mw_rst_strobe", 32'(MemWrite), 32'd0);
    chk("mw_rst_irw", 32'(IRWrite), 32'd0);
    chk("mw_rst_pcw", 32'(PCWrite), 32'd0);
    @(negedge clk) reset = 1'b0; MemReady = 1'b0;
    run_instr("post_rst_r", 7'h33, 3'b111, 7'h00, 1'b0, 1, 0);

    for (int n = 0; n < 250; n++) begin
      rop = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
      run_instr($sformatf("rnd%0d", n), rop, 3'($urandom),
                ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'(($urandom_range(0, 2) == 0) ? 7'h20 :
                ($urandom_range(0, 1) == 0) ? 7'h01 : 7'h00),
                1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
